alu_iter: RTL and testbench
===========================

Name: alu_iter

Overview:
- Parametrised, multi-cycle successor to the CPU ALU datapath.
- Single-cycle ops: add/sub/logic/shift/compare. Iterative ops: shift-add multiply and restoring divide.
- Uses a Start/Busy/Done handshake so the control unit can stall on long ops.
- Sits between decoder/register file and the status register. Produces Result, ResultHi and SetSR.

Parameters:
- WIDTH, 32, operand/result width; power of two, >= 8.
- SEL_W, 8, opcode width (ALU_Sel).
- SHW, $clog2(WIDTH), shift-amount bits taken from B.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- A  in  WIDTH  operand A.
- B  in  WIDTH  operand B.
- ALU_Sel  in  SEL_W  opcode, sampled with Start.
- CarryIn  in  1  carry flag from status register, used by ADC/SBB.
- Start  in  1  request; accepted only when Busy=0.
- Busy  out  1  operation in progress.
- Done  out  1  one-cycle pulse; Result/ResultHi/SetSR are updated on the same edge.
- Result  out  WIDTH  main result (product low / quotient).
- ResultHi  out  WIDTH  product high / remainder; 0 for single-cycle ops.
- SetSR  out  8  flags: [0]C [1]Z [2]N [3]V [4]DZ [5]ILL, [7:6]=0.

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; Busy, Done, Result, ResultHi and SetSR all 0. Reset mid-operation discards the operation with no Done.
- Opcodes:
  - 0 ADD, 1 ADC, 2 SUB (A-B), 3 SBB (A-B-CarryIn).
  - 4 AND, 5 OR, 6 XOR, 7 NOT A.
  - 8 SHL, 9 SHR logical, 10 SAR; shift amount is B[SHW-1:0].
  - 11 MULU, 12 MULS, 13 DIVU.
  - 14 CMP: flags of A-B only; Result and ResultHi hold their previous values.
  - Others: ILL.
- States: IDLE, MUL, DIV, FIN.
- IDLE + Start with a single-cycle op or ILL:
  - Result/SetSR registered on the accepting edge; Done=1 for the following cycle; stay IDLE.
  - Back-to-back Starts are allowed, one result per cycle.
- IDLE + Start with MULU/MULS:
  - Latch operands (magnitudes for MULS); Busy=1; go to MUL.
  - WIDTH iterations, then FIN applies sign and flags.
  - Done pulses on edge WIDTH+1 after the accepting edge; Busy falls on that same edge.
- DIVU behaves the same way via DIV; Result=quotient, ResultHi=remainder.
- DIVU with B=0:
  - No iteration. Result = all ones, ResultHi = A, DZ=1.
  - Done after 1 cycle, as for a single-cycle op.
- Start while Busy=1 is ignored; operands and ALU_Sel are not re-sampled during an iterative op.
- Flags:
  - Z: Result==0; for MUL, the full 2*WIDTH product ==0.
  - N: MSB of Result; for MULS, MSB of ResultHi.
  - C: carry-out for ADD/ADC; borrow for SUB/SBB/CMP; last bit shifted out for shifts (0 when amount=0); ResultHi!=0 for MULU; 0 otherwise.
  - V: signed overflow for add/sub/CMP; for MULS, product does not fit in WIDTH signed bits; 0 otherwise.
  - ILL: all other flags 0, Result 0.
- Arithmetic is modulo 2^WIDTH. Signed ops treat operands as two's complement.

Optional Feature:
- Macro ALU_ITER_ABORT_EN.
- Defined: adds input Abort (1 bit). Abort=1 while Busy=1 returns to IDLE on the next edge with Busy=0, no Done, and Result/ResultHi/SetSR unchanged. Abort in IDLE is ignored; Abort has priority over a same-cycle Start.
- Undefined: no Abort port; iterative ops always run to completion.

Test Plan:
- WIDTH=32, ADD A=0xFFFFFFFF B=1 -> Done next cycle, Result=0, SetSR C=1 Z=1 N=0 V=0.
- SUB A=0xFFFFFEAF (-337) B=28 -> Result=0xFFFFFE93, N=1 C=0 V=0; SAR A=0x80000000 B=31 -> Result=0xFFFFFFFF, C=0, N=1.
- MULS A=-337 B=28 -> Busy for 33 edges, Done exactly 33 edges after Start, Result=0xFFFFDB24, ResultHi=0xFFFFFFFF, N=1 V=0; second Start at cycle 5 is ignored.
- DIVU A=395 B=10 -> Result=39, ResultHi=5, DZ=0 after 33 edges; DIVU A=395 B=0 -> Done after 1 edge, Result=0xFFFFFFFF, ResultHi=395, DZ=1.
- Reset (rst=0) asserted 10 cycles into MULU 0xFFFFFFFF*0xFFFFFFFF -> Busy, Done, Result and SetSR are 0 immediately; rerun after reset gives ResultHi=0xFFFFFFFE, Result=1, C=1.
- ALU_ITER_ABORT_EN: Abort at cycle 7 of DIVU -> Busy=0 next edge, no Done pulse, previous Result retained; opcode 200 -> ILL=1, Result=0.

Source files
------------

// File: rtl/alu_iter_if.sv
// rtl/alu_iter_if.sv - operand/handshake bundle between the control unit and alu_iter
//
// Signals:
//   A, B      operands                 ALU_Sel  opcode, sampled with Start
//   CarryIn   status-register carry    Start    request, taken only while Busy=0
//   Abort     cancel a busy op (only when ALU_ITER_ABORT_EN is defined)
//   Busy      operation in progress    Done     one-cycle completion pulse
//   Result    result / product low / quotient
//   ResultHi  product high / remainder SetSR    flags {0,0,ILL,DZ,V,N,Z,C}
// Modports: master = control unit side, slave = ALU side.
interface alu_iter_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 8
);
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [SEL_W-1:0] ALU_Sel;
    logic             CarryIn;
    logic             Start;
`ifdef ALU_ITER_ABORT_EN
    logic             Abort;
`endif
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] Result;
    logic [WIDTH-1:0] ResultHi;
    logic [7:0]       SetSR;

`ifdef ALU_ITER_ABORT_EN
    modport master (
        output A, B, ALU_Sel, CarryIn, Start, Abort,
        input  Busy, Done, Result, ResultHi, SetSR
    );
    modport slave (
        input  A, B, ALU_Sel, CarryIn, Start, Abort,
        output Busy, Done, Result, ResultHi, SetSR
    );
`else
    modport master (
        output A, B, ALU_Sel, CarryIn, Start,
        input  Busy, Done, Result, ResultHi, SetSR
    );
    modport slave (
        input  A, B, ALU_Sel, CarryIn, Start,
        output Busy, Done, Result, ResultHi, SetSR
    );
`endif
endinterface

// File: rtl/alu_iter.sv
// rtl/alu_iter.sv - multi-cycle ALU: single-cycle arith/logic/shift/compare, iterative multiply and divide
//
// Ports:
//   clk   rising-edge clock
//   rst   asynchronous active-low reset
//   bus   alu_iter_if.slave: A, B, ALU_Sel, CarryIn, Start (, Abort) in;
//         Busy, Done, Result, ResultHi, SetSR out
// Optional feature: define ALU_ITER_ABORT_EN to honour bus.Abort while Busy.
//
// Single-cycle ops (and ILL, and DIVU by zero) register their result on the
// accepting edge and pulse Done in the following cycle. MULU/MULS/DIVU run
// WIDTH iterations in MUL/DIV, then FIN applies sign and flags, so Done lands
// WIDTH+1 edges after the accepting edge.
module alu_iter #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic       clk,
    input  logic       rst,
    alu_iter_if.slave  bus
);

    localparam logic [SEL_W-1:0] OP_ADD  = SEL_W'(0);
    localparam logic [SEL_W-1:0] OP_ADC  = SEL_W'(1);
    localparam logic [SEL_W-1:0] OP_SUB  = SEL_W'(2);
    localparam logic [SEL_W-1:0] OP_SBB  = SEL_W'(3);
    localparam logic [SEL_W-1:0] OP_AND  = SEL_W'(4);
    localparam logic [SEL_W-1:0] OP_OR   = SEL_W'(5);
    localparam logic [SEL_W-1:0] OP_XOR  = SEL_W'(6);
    localparam logic [SEL_W-1:0] OP_NOT  = SEL_W'(7);
    localparam logic [SEL_W-1:0] OP_SHL  = SEL_W'(8);
    localparam logic [SEL_W-1:0] OP_SHR  = SEL_W'(9);
    localparam logic [SEL_W-1:0] OP_SAR  = SEL_W'(10);
    localparam logic [SEL_W-1:0] OP_MULU = SEL_W'(11);
    localparam logic [SEL_W-1:0] OP_MULS = SEL_W'(12);
    localparam logic [SEL_W-1:0] OP_DIVU = SEL_W'(13);
    localparam logic [SEL_W-1:0] OP_CMP  = SEL_W'(14);

    localparam int MSB = WIDTH - 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_FIN  = 2'd3
    } state_t;

    state_t state_q, state_d;
    logic   busy;
    logic   abort;

    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d;      // product high / partial remainder
    logic [WIDTH-1:0] lo_q, lo_d;      // multiplier / dividend, becomes product low / quotient
    logic [WIDTH-1:0] opb_q, opb_d;    // multiplicand magnitude / divisor
    logic             neg_q, neg_d;    // MULS product must be negated in FIN
    logic             muls_q, muls_d;
    logic             isdiv_q, isdiv_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] result_hi_q, result_hi_d;
    logic [7:0]       setsr_q, setsr_d;
    logic             done_q, done_d;

`ifdef ALU_ITER_ABORT_EN
    assign abort = bus.Abort;
`else
    assign abort = 1'b0;
`endif

    // ---------------------------------------------------------------
    // Opcode classification
    // ---------------------------------------------------------------
    logic is_mul;
    logic is_div_iter;

    assign is_mul      = (bus.ALU_Sel == OP_MULU) || (bus.ALU_Sel == OP_MULS);
    // Division by zero is resolved in one cycle, so it is not iterative.
    assign is_div_iter = (bus.ALU_Sel == OP_DIVU) && (bus.B != '0);

    // ---------------------------------------------------------------
    // Single-cycle datapath
    // ---------------------------------------------------------------
    logic [WIDTH:0]   add_w;
    logic [WIDTH:0]   sub_w;
    logic [WIDTH:0]   shl_w;
    logic [WIDTH:0]   shr_w;
    logic [WIDTH:0]   sar_w;
    logic [SHW-1:0]   amt;
    logic             add_cin;
    logic             sub_bin;
    logic [WIDTH-1:0] sc_res;
    logic [WIDTH-1:0] sc_hi;
    logic             sc_c, sc_v, sc_z, sc_n, sc_dz, sc_ill, sc_hold;

    assign amt     = bus.B[SHW-1:0];
    assign add_cin = (bus.ALU_Sel == OP_ADC) & bus.CarryIn;
    assign sub_bin = (bus.ALU_Sel == OP_SBB) & bus.CarryIn;
    assign add_w   = {1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, add_cin};
    // Bit WIDTH of the widened difference is the borrow.
    assign sub_w   = {1'b0, bus.A} - {1'b0, bus.B} - {{WIDTH{1'b0}}, sub_bin};
    // One extra bit beside the operand catches the last bit shifted out;
    // it is naturally 0 for a zero shift amount.
    assign shl_w   = {1'b0, bus.A} << amt;
    assign shr_w   = {bus.A, 1'b0} >> amt;
    assign sar_w   = $signed({bus.A, 1'b0}) >>> amt;

    always_comb begin
        sc_res  = '0;
        sc_hi   = '0;
        sc_c    = 1'b0;
        sc_v    = 1'b0;
        sc_dz   = 1'b0;
        sc_ill  = 1'b0;
        sc_hold = 1'b0;
        case (bus.ALU_Sel)
            OP_ADD, OP_ADC: begin
                sc_res = add_w[MSB:0];
                sc_c   = add_w[WIDTH];
                sc_v   = (bus.A[MSB] == bus.B[MSB]) && (add_w[MSB] != bus.A[MSB]);
            end
            OP_SUB, OP_SBB, OP_CMP: begin
                sc_res  = sub_w[MSB:0];
                sc_c    = sub_w[WIDTH];
                sc_v    = (bus.A[MSB] != bus.B[MSB]) && (sub_w[MSB] != bus.A[MSB]);
                sc_hold = (bus.ALU_Sel == OP_CMP);
            end
            OP_AND: sc_res = bus.A & bus.B;
            OP_OR:  sc_res = bus.A | bus.B;
            OP_XOR: sc_res = bus.A ^ bus.B;
            OP_NOT: sc_res = ~bus.A;
            OP_SHL: begin
                sc_res = shl_w[MSB:0];
                sc_c   = shl_w[WIDTH];
            end
            OP_SHR: begin
                sc_res = shr_w[WIDTH:1];
                sc_c   = shr_w[0];
            end
            OP_SAR: begin
                sc_res = sar_w[WIDTH:1];
                sc_c   = sar_w[0];
            end
            OP_DIVU: begin
                // Only reached as a single-cycle op when B is zero.
                sc_res = '1;
                sc_hi  = bus.A;
                sc_dz  = 1'b1;
            end
            default: sc_ill = 1'b1;
        endcase
        sc_z = !sc_ill && (sc_res == '0);
        sc_n = !sc_ill && sc_res[MSB];
    end

    // ---------------------------------------------------------------
    // Iteration steps
    // ---------------------------------------------------------------
    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_trial;
    logic               div_ge;
    logic [WIDTH-1:0]   div_diff;
    logic [2*WIDTH-1:0] prod_mag;
    logic [2*WIDTH-1:0] prod_fin;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;

    // Shift-add: conditionally add the multiplicand to the high half, then
    // shift the {carry, hi, lo} chain right by one.
    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    // Restoring divide: bring the next dividend bit into the remainder and
    // subtract the divisor only when it fits.
    assign div_trial = {hi_q, lo_q[MSB]};
    assign div_ge    = (div_trial >= {1'b0, opb_q});
    assign div_diff  = div_trial[MSB:0] - opb_q;

    assign prod_mag  = {hi_q, lo_q};
    assign prod_fin  = neg_q ? -prod_mag : prod_mag;

    assign a_mag     = bus.A[MSB] ? -bus.A : bus.A;
    assign b_mag     = bus.B[MSB] ? -bus.B : bus.B;

    // ---------------------------------------------------------------
    // FSM: state register
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------------------------------------------------------
    // FSM: next state
    // ---------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    if (is_mul) begin
                        state_d = S_MUL;
                    end else if (is_div_iter) begin
                        state_d = S_DIV;
                    end
                end
            end
            S_MUL, S_DIV: begin
                if (abort) begin
                    state_d = S_IDLE;
                end else if (cnt_q == SHW'(WIDTH - 1)) begin
                    state_d = S_FIN;
                end
            end
            S_FIN:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // ---------------------------------------------------------------
    // FSM: outputs
    // ---------------------------------------------------------------
    always_comb begin
        busy = (state_q != S_IDLE);
    end

    // ---------------------------------------------------------------
    // Datapath next state
    // ---------------------------------------------------------------
    always_comb begin
        cnt_d       = cnt_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        opb_d       = opb_q;
        neg_d       = neg_q;
        muls_d      = muls_q;
        isdiv_d     = isdiv_q;
        result_d    = result_q;
        result_hi_d = result_hi_q;
        setsr_d     = setsr_q;
        done_d      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.Start) begin
                    if (is_mul) begin
                        muls_d  = (bus.ALU_Sel == OP_MULS);
                        neg_d   = (bus.ALU_Sel == OP_MULS) && (bus.A[MSB] ^ bus.B[MSB]);
                        hi_d    = '0;
                        lo_d    = (bus.ALU_Sel == OP_MULS) ? a_mag : bus.A;
                        opb_d   = (bus.ALU_Sel == OP_MULS) ? b_mag : bus.B;
                        cnt_d   = '0;
                        isdiv_d = 1'b0;
                    end else if (is_div_iter) begin
                        muls_d  = 1'b0;
                        neg_d   = 1'b0;
                        hi_d    = '0;
                        lo_d    = bus.A;
                        opb_d   = bus.B;
                        cnt_d   = '0;
                        isdiv_d = 1'b1;
                    end else begin
                        done_d  = 1'b1;
                        if (!sc_hold) begin
                            result_d    = sc_res;
                            result_hi_d = sc_hi;
                        end
                        setsr_d = {2'b00, sc_ill, sc_dz, sc_v, sc_n, sc_z, sc_c};
                    end
                end
            end
            S_MUL: begin
                if (!abort) begin
                    hi_d  = mul_sum[WIDTH:1];
                    lo_d  = {mul_sum[0], lo_q[MSB:1]};
                    cnt_d = cnt_q + SHW'(1);
                end
            end
            S_DIV: begin
                if (!abort) begin
                    hi_d  = div_ge ? div_diff : div_trial[MSB:0];
                    lo_d  = {lo_q[MSB-1:0], div_ge};
                    cnt_d = cnt_q + SHW'(1);
                end
            end
            S_FIN: begin
                if (!abort) begin
                    done_d = 1'b1;
                    if (isdiv_q) begin
                        result_d    = lo_q;
                        result_hi_d = hi_q;
                        setsr_d     = {4'b0000, 1'b0, lo_q[MSB], (lo_q == '0), 1'b0};
                    end else begin
                        result_d    = prod_fin[MSB:0];
                        result_hi_d = prod_fin[2*WIDTH-1:WIDTH];
                        // MULS overflows when the high half is not a pure
                        // sign extension of the low half.
                        setsr_d     = {4'b0000,
                                       muls_q && (prod_fin[2*WIDTH-1:WIDTH] != {WIDTH{prod_fin[MSB]}}),
                                       muls_q ? prod_fin[2*WIDTH-1] : prod_fin[MSB],
                                       (prod_mag == '0),
                                       !muls_q && (prod_fin[2*WIDTH-1:WIDTH] != '0)};
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------------
    // Datapath registers
    // ---------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            opb_q       <= '0;
            neg_q       <= 1'b0;
            muls_q      <= 1'b0;
            isdiv_q     <= 1'b0;
            result_q    <= '0;
            result_hi_q <= '0;
            setsr_q     <= '0;
            done_q      <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            opb_q       <= opb_d;
            neg_q       <= neg_d;
            muls_q      <= muls_d;
            isdiv_q     <= isdiv_d;
            result_q    <= result_d;
            result_hi_q <= result_hi_d;
            setsr_q     <= setsr_d;
            done_q      <= done_d;
        end
    end

    assign bus.Busy     = busy;
    assign bus.Done     = done_q;
    assign bus.Result   = result_q;
    assign bus.ResultHi = result_hi_q;
    assign bus.SetSR    = setsr_q;

endmodule

// File: tb/tb_alu_iter.sv
// tb/tb_alu_iter.sv - scoreboard bench for alu_iter with directed and random operations
module tb_alu_iter;

    localparam int W = 32;
    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    typedef struct {
        logic [7:0]  sel;
        logic [31:0] res;
        logic [31:0] hi;
        logic [7:0]  sr;
        bit          iter;
        int unsigned cyc;
    } exp_t;

    logic clk;
    logic rst;
    int unsigned cyc = 0;
    int n_tests = 0;
    int n_fail  = 0;

    exp_t sb_q[$];
    logic [31:0] m_res = '0;
    logic [31:0] m_hi  = '0;
    logic [7:0]  m_sr  = '0;

    alu_iter_if #(.WIDTH(W), .SEL_W(8)) bus ();

    alu_iter #(.WIDTH(W), .SEL_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h required 0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: plain wide arithmetic on the opcode definitions.
    function automatic exp_t model(input logic [7:0] sel, input logic [31:0] a, input logic [31:0] b,
                                   input logic cin);
        exp_t e;
        logic [63:0] ua, ub, full, p;
        longint sa, sb, sfull, sp, ci;
        int amt;
        logic c, v, dz, ill, z, n;
        logic [31:0] res, hi;
        ua = {32'b0, a};
        ub = {32'b0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        amt = int'(b[4:0]);
        ci = (cin && (sel == 8'd1 || sel == 8'd3)) ? 64'sd1 : 64'sd0;
        res = '0; hi = '0; c = 0; v = 0; dz = 0; ill = 0; full = '0; p = '0; sp = 0;
        e.iter = 0;
        case (sel)
            8'd0, 8'd1: begin
                full = ua + ub + 64'(ci);
                res = full[31:0];
                c = full[32];
                sfull = sa + sb + ci;
                v = (sfull > SMAX) || (sfull < SMIN);
            end
            8'd2, 8'd3, 8'd14: begin
                full = ua - ub - 64'(ci);
                res = full[31:0];
                c = (ua < ub + 64'(ci));
                sfull = sa - sb - ci;
                v = (sfull > SMAX) || (sfull < SMIN);
            end
            8'd4: res = a & b;
            8'd5: res = a | b;
            8'd6: res = a ^ b;
            8'd7: res = ~a;
            8'd8: begin
                full = ua << amt;
                res = full[31:0];
                c = full[32];
            end
            8'd9: begin
                res = a >> amt;
                c = (amt == 0) ? 1'b0 : a[amt-1];
            end
            8'd10: begin
                sfull = sa >>> amt;
                res = sfull[31:0];
                c = (amt == 0) ? 1'b0 : a[amt-1];
            end
            8'd11: begin
                p = ua * ub;
                res = p[31:0];
                hi = p[63:32];
                c = (hi != 0);
                e.iter = 1;
            end
            8'd12: begin
                sp = sa * sb;
                p = sp;
                res = p[31:0];
                hi = p[63:32];
                v = (sp > SMAX) || (sp < SMIN);
                e.iter = 1;
            end
            8'd13: begin
                if (b == 0) begin
                    res = 32'hFFFF_FFFF;
                    hi = a;
                    dz = 1;
                end else begin
                    res = a / b;
                    hi = a % b;
                    e.iter = 1;
                end
            end
            default: ill = 1;
        endcase
        if (ill) begin
            z = 0; n = 0;
        end else if (sel == 8'd11 || sel == 8'd12) begin
            z = (p == 0);
            n = (sel == 8'd12) ? hi[31] : res[31];
        end else begin
            z = (res == 0);
            n = res[31];
        end
        e.sel = sel;
        e.res = res;
        e.hi  = hi;
        e.sr  = {2'b00, ill, dz, v, n, z, c};
        e.cyc = 0;
        return e;
    endfunction

    // Drive one request at a negedge; it is accepted on the following edge.
    task automatic issue(input logic [7:0] sel, input logic [31:0] a, input logic [31:0] b, input logic cin);
        exp_t e;
        e = model(sel, a, b, cin);
        if (sel == 8'd14) begin
            e.res = m_res;
            e.hi  = m_hi;
        end
        m_res = e.res;
        m_hi  = e.hi;
        m_sr  = e.sr;
        e.cyc = cyc + 1 + (e.iter ? 33 : 0);
        sb_q.push_back(e);
        bus.ALU_Sel = sel;
        bus.A = a;
        bus.B = b;
        bus.CarryIn = cin;
        bus.Start = 1'b1;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        for (int k = 0; k < 100 && bus.Busy; k++) @(negedge clk);
        if (bus.Busy) check(nm, 64'(bus.Busy), 64'd0);
    endtask

    // Monitor: every Done must match the oldest outstanding expectation.
    always @(negedge clk) begin : mon
        exp_t e;
        if (rst && bus.Done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb_q.pop_front();
                check($sformatf("op%0d_done_cycle", e.sel), 64'(cyc), 64'(e.cyc));
                check($sformatf("op%0d_result", e.sel), 64'(bus.Result), 64'(e.res));
                check($sformatf("op%0d_result_hi", e.sel), 64'(bus.ResultHi), 64'(e.hi));
                check($sformatf("op%0d_setsr", e.sel), 64'(bus.SetSR), 64'(e.sr));
            end
        end
    end

    initial begin
        logic [7:0]  sel;
        logic [31:0] a, b;
        logic [31:0] save_res, save_hi;
        logic [7:0]  save_sr;
        int busy_cnt;
        int r;

        bus.A = '0; bus.B = '0; bus.ALU_Sel = '0; bus.CarryIn = 1'b0; bus.Start = 1'b0;
`ifdef ALU_ITER_ABORT_EN
        bus.Abort = 1'b0;
`endif
        rst = 1'b1;
        #3 rst = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(bus.Busy), 64'd0);
        check("reset_done", 64'(bus.Done), 64'd0);
        check("reset_result", 64'(bus.Result), 64'd0);
        check("reset_result_hi", 64'(bus.ResultHi), 64'd0);
        check("reset_setsr", 64'(bus.SetSR), 64'd0);
        rst = 1'b1;
        @(negedge clk);

        // Directed single-cycle cases, back to back.
        issue(8'd0,  32'hFFFF_FFFF, 32'd1, 1'b0);
        issue(8'd2,  32'hFFFF_FEAF, 32'd28, 1'b0);
        issue(8'd10, 32'h8000_0000, 32'd31, 1'b0);
        issue(8'd8,  32'h1234_5678, 32'd0, 1'b1);
        issue(8'd14, 32'd5, 32'd5, 1'b0);
        issue(8'd3,  32'h8000_0000, 32'd0, 1'b1);

        // MULS with an ignored Start (and changed operands) mid-operation.
        issue(8'd12, 32'hFFFF_FEAF, 32'd28, 1'b0);
        busy_cnt = 0;
        for (int k = 0; k < 60; k++) begin
            if (!bus.Busy) break;
            busy_cnt++;
            bus.Start = (busy_cnt == 5);
            bus.ALU_Sel = 8'd0;
            bus.A = 32'd7;
            bus.B = 32'd9;
            @(negedge clk);
        end
        bus.Start = 1'b0;
        check("muls_busy_cycles", 64'(busy_cnt), 64'd33);

        issue(8'd13, 32'd395, 32'd10, 1'b0);
        wait_idle("divu_wait");
        issue(8'd13, 32'd395, 32'd0, 1'b0);
        issue(8'd200, 32'h1234_5678, 32'h1, 1'b1);

        // Reset in the middle of MULU.
        save_res = m_res;
        issue(8'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_busy", 64'(bus.Busy), 64'd0);
        check("midrst_done", 64'(bus.Done), 64'd0);
        check("midrst_result", 64'(bus.Result), 64'd0);
        check("midrst_result_hi", 64'(bus.ResultHi), 64'd0);
        check("midrst_setsr", 64'(bus.SetSR), 64'd0);
        void'(sb_q.pop_back());
        m_res = '0; m_hi = '0; m_sr = '0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        issue(8'd11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_idle("mulu_wait");

`ifdef ALU_ITER_ABORT_EN
        save_res = m_res; save_hi = m_hi; save_sr = m_sr;
        issue(8'd13, 32'd395, 32'd10, 1'b0);
        repeat (5) @(negedge clk);
        bus.Abort = 1'b1;
        @(negedge clk);
        bus.Abort = 1'b0;
        check("abort_busy", 64'(bus.Busy), 64'd0);
        check("abort_done", 64'(bus.Done), 64'd0);
        check("abort_result", 64'(bus.Result), 64'(save_res));
        check("abort_result_hi", 64'(bus.ResultHi), 64'(save_hi));
        check("abort_setsr", 64'(bus.SetSR), 64'(save_sr));
        void'(sb_q.pop_back());
        m_res = save_res; m_hi = save_hi; m_sr = save_sr;
        // Abort while idle does not block a Start.
        bus.Abort = 1'b1;
        issue(8'd0, 32'd3, 32'd4, 1'b0);
        bus.Abort = 1'b0;
`else
        save_sr = 8'h00;
        save_hi = save_res ^ {24'b0, save_sr};
`endif

        // Random operations.
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 19);
            sel = (r < 16) ? 8'(r) : 8'($urandom_range(16, 255));
            a = $urandom;
            b = $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 40));
            if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 3)) << 30;
            if (sel == 8'd13 && $urandom_range(0, 4) == 0) b = '0;
            issue(sel, a, b, 1'($urandom_range(0, 1)));
            if (sel == 8'd11 || sel == 8'd12 || sel == 8'd13) wait_idle("rand_wait");
        end

        for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(negedge clk);
        check("drain_empty", 64'(sb_q.size()), 64'd0);
        repeat (3) @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
